// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser trace path: word field layout and
// decoder state encoding, used by both the encoder and the decoder.
package la_pkg;

  localparam int pSIG_WIDTH    = 24;
  localparam int pRC_WIDTH     = 8;
  localparam int LA_USER_WIDTH = 2;

  // Trace word layout: repeat count above the signal field.
  localparam int LA_SIG_LSB = 0;
  localparam int LA_SIG_MSB = pSIG_WIDTH - 1;
  localparam int LA_RC_LSB  = pSIG_WIDTH;
  localparam int LA_RC_MSB  = pSIG_WIDTH + pRC_WIDTH - 1;

  typedef logic [0:0] la_state_t;
  localparam la_state_t LA_IDLE   = 1'b0;
  localparam la_state_t LA_EXPAND = 1'b1;

endpackage

// File: rtl/la_sat_counter.sv
// Event counter with synchronous clear; pSATURATE selects sticking at all-ones
// instead of wrapping.
module la_sat_counter #(
  parameter int pWIDTH    = 16,
  parameter bit pSATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [pWIDTH-1:0] o_count
);

  localparam logic [pWIDTH-1:0] ONE = {{(pWIDTH-1){1'b0}}, 1'b1};

  logic [pWIDTH-1:0] r_count;
  logic              w_hold;

  assign w_hold = pSATURATE && (&r_count);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_hold) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/la_trace_decoder.sv
// Expands run-length trace words {rc, signals} into rc back-to-back samples,
// flagging rc=0 overflow records and marking the first sample after them.
module la_trace_decoder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pSIG_WIDTH  = la_pkg::pSIG_WIDTH,
  parameter int pRC_WIDTH   = la_pkg::pRC_WIDTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  input  logic [1:0]             s_tuser,
  output logic [pSIG_WIDTH-1:0]  m_sample,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   m_resync,
  output logic [1:0]             m_user,
  input  logic                   soft_clr,
  output logic                   ovf_flag,
  output logic [15:0]            ovf_count,
  output logic [31:0]            sample_count
);

  import la_pkg::*;

  localparam logic [pRC_WIDTH-1:0] RC_ONE = {{(pRC_WIDTH-1){1'b0}}, 1'b1};

  la_state_t              r_state;
  logic [pRC_WIDTH-1:0]   r_rem;
  logic [pSIG_WIDTH-1:0]  r_sig;
  logic [1:0]             r_user;
  logic                   r_last;
  logic                   r_first;
  logic                   r_resync_pend;
  logic                   r_ovf_flag;
  logic                   r_rdy_en;

  logic [pRC_WIDTH-1:0]   w_rc;
  logic [pSIG_WIDTH-1:0]  w_sig;
  logic                   w_rc_zero;
  logic                   w_take;
  logic                   w_fire;
  logic                   w_rem_one;
  logic                   w_expand;

  assign w_rc      = s_tdata[pSIG_WIDTH +: pRC_WIDTH];
  assign w_sig     = s_tdata[pSIG_WIDTH-1:0];
  assign w_rc_zero = (w_rc == '0);
  assign w_expand  = (r_state == LA_EXPAND);
  assign w_rem_one = (r_rem == RC_ONE);

  // A new word is only taken while the final held sample leaves, so records
  // chain without a bubble; r_rdy_en keeps s_tready low until the first edge
  // after reset.
  assign s_tready = r_rdy_en && (!w_expand || (w_rem_one && m_ready));
  assign w_take   = s_tvalid && s_tready;
  assign w_fire   = m_valid && m_ready;

  assign m_valid  = w_expand;
  assign m_sample = r_sig;
  assign m_user   = r_user;
  assign m_last   = w_expand && w_rem_one && r_last;
  assign m_resync = w_expand && r_first && r_resync_pend;
  assign ovf_flag = r_ovf_flag;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state       <= LA_IDLE;
      r_rem         <= '0;
      r_sig         <= '0;
      r_user        <= '0;
      r_last        <= 1'b0;
      r_first       <= 1'b0;
      r_resync_pend <= 1'b0;
      r_ovf_flag    <= 1'b0;
    end else if (soft_clr) begin
      r_state       <= LA_IDLE;
      r_rem         <= '0;
      r_sig         <= '0;
      r_user        <= '0;
      r_last        <= 1'b0;
      r_first       <= 1'b0;
      r_resync_pend <= 1'b0;
      r_ovf_flag    <= 1'b0;
    end else begin
      if (w_take && !w_rc_zero) begin
        r_state <= LA_EXPAND;
        r_rem   <= w_rc;
        r_sig   <= w_sig;
        r_user  <= s_tuser;
        r_last  <= s_tlast;
        r_first <= 1'b1;
      end else if (w_fire) begin
        // An rc=0 word taken here also lands in this branch and ends in IDLE.
        r_rem   <= r_rem - RC_ONE;
        r_first <= 1'b0;
        if (w_rem_one) begin
          r_state <= LA_IDLE;
        end
      end

      // A fresh overflow wins over clearing on a simultaneous resync sample.
      if (w_take && w_rc_zero) begin
        r_resync_pend <= 1'b1;
        r_ovf_flag    <= 1'b1;
      end else if (w_fire && r_first) begin
        r_resync_pend <= 1'b0;
      end
    end
  end

  la_sat_counter #(
    .pWIDTH   (16),
    .pSATURATE(1'b1)
  ) u_ovf_count (
    .clk    (axis_clk),
    .rst_n  (axis_rst_n),
    .i_clr  (soft_clr),
    .i_inc  (w_take && w_rc_zero),
    .o_count(ovf_count)
  );

  la_sat_counter #(
    .pWIDTH   (32),
    .pSATURATE(1'b0)
  ) u_sample_count (
    .clk    (axis_clk),
    .rst_n  (axis_rst_n),
    .i_clr  (soft_clr),
    .i_inc  (w_fire),
    .o_count(sample_count)
  );

endmodule

// File: tb/tb_la_trace_decoder.sv
// Bench for la_trace_decoder: a queue of expected samples built from each
// accepted record is compared with the DUT every cycle, plus directed scenarios.
module tb_la_trace_decoder;

  import la_pkg::*;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [1:0]  s_tuser = '0;
  logic [23:0] m_sample;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        m_resync;
  logic [1:0]  m_user;
  logic        soft_clr = 1'b0;
  logic        ovf_flag;
  logic [15:0] ovf_count;
  logic [31:0] sample_count;

  la_trace_decoder dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_sample    (m_sample),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .m_resync    (m_resync),
    .m_user      (m_user),
    .soft_clr    (soft_clr),
    .ovf_flag    (ovf_flag),
    .ovf_count   (ovf_count),
    .sample_count(sample_count)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [23:0] sig;
    logic [1:0]  user;
    logic        last;
    logic        resync;
  } smp_t;

  smp_t        q[$];
  bit          mdl_pend;
  bit          mdl_flag;
  bit          mdl_rdy_ok;
  int unsigned mdl_ovf;
  logic [31:0] mdl_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] word(input int rc, input logic [23:0] sig);
    logic [7:0] rc8;
    rc8 = rc[7:0];
    return {rc8, sig};
  endfunction

  // One clock: drive inputs at the falling edge, compare the DUT with the
  // model, then advance the model by what the coming rising edge will do.
  task automatic step(input logic vld, input logic [31:0] data, input logic [1:0] user,
                      input logic last, input logic mrdy, input logic clr, input logic rst);
    logic exp_rdy;
    logic take;
    logic fire;
    smp_t h;
    int   rc;
    @(negedge axis_clk);
    s_tvalid = vld; s_tdata = data; s_tuser = user; s_tlast = last;
    m_ready = mrdy; soft_clr = clr; axis_rst_n = rst;
    #1;
    if (!rst) begin
      q.delete(); mdl_pend = 0; mdl_flag = 0; mdl_ovf = 0; mdl_cnt = '0; mdl_rdy_ok = 0;
    end
    exp_rdy = mdl_rdy_ok && (q.size() == 0 || (q.size() == 1 && mrdy));
    n_tests++;
    if (s_tready !== exp_rdy) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL s_tready @%0t got %b want %b", $time, s_tready, exp_rdy);
    end
    n_tests++;
    if (m_valid !== (q.size() != 0)) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL m_valid @%0t got %b want %b", $time, m_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      h = q[0];
      n_tests++;
      if ({m_sample, m_user, m_last, m_resync} !== h) begin
        n_fail++;
        if (n_fail <= 40)
          $display("FAIL sample @%0t got sig=%h user=%0d last=%b resync=%b want sig=%h user=%0d last=%b resync=%b",
                   $time, m_sample, m_user, m_last, m_resync, h.sig, h.user, h.last, h.resync);
      end
    end else begin
      n_tests++;
      if ({m_last, m_resync} !== 2'b00) begin
        n_fail++;
        if (n_fail <= 40) $display("FAIL idle_flags @%0t got last=%b resync=%b want 0 0", $time, m_last, m_resync);
      end
    end
    n_tests++;
    if ({ovf_flag, ovf_count, sample_count} !== {mdl_flag, mdl_ovf[15:0], mdl_cnt}) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL counters @%0t got flag=%b ovf=%h cnt=%0d want flag=%b ovf=%h cnt=%0d",
                 $time, ovf_flag, ovf_count, sample_count, mdl_flag, mdl_ovf[15:0], mdl_cnt);
    end
    if (!rst) begin
      n_tests++;
      if ({m_sample, m_user} !== 26'd0) begin
        n_fail++;
        if (n_fail <= 40) $display("FAIL reset_data @%0t got sig=%h user=%0d want 0", $time, m_sample, m_user);
      end
    end
    take = vld && (s_tready === 1'b1);
    fire = (m_valid === 1'b1) && mrdy;
    if (rst && clr) begin
      q.delete(); mdl_pend = 0; mdl_flag = 0; mdl_ovf = 0; mdl_cnt = '0;
    end else if (rst) begin
      if (fire && q.size() != 0) begin
        void'(q.pop_front());
        mdl_cnt++;
      end
      if (take) begin
        rc = int'(data[LA_RC_MSB:LA_RC_LSB]);
        if (rc == 0) begin
          mdl_flag = 1;
          mdl_pend = 1;
          if (mdl_ovf < 32'hFFFF) mdl_ovf++;
        end else begin
          for (int i = 0; i < rc; i++) begin
            h.sig = data[LA_SIG_MSB:LA_SIG_LSB];
            h.user = user;
            h.last = last && (i == rc - 1);
            h.resync = mdl_pend && (i == 0);
            q.push_back(h);
          end
          mdl_pend = 0;
        end
      end
    end
    mdl_rdy_ok = rst;
  endtask

  task automatic idle(input logic mrdy);
    step(1'b0, '0, 2'd0, 1'b0, mrdy, 1'b0, 1'b1);
  endtask

  task automatic clear();
    step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) begin
      step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({s_tready, m_valid, ovf_flag, ovf_count, sample_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got rdy=%b vld=%b flag=%b ovf=%h cnt=%h want all 0",
                 s_tready, m_valid, ovf_flag, ovf_count, sample_count);
      end
    end
    step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge got %b want 0", s_tready);
    end
    idle(1'b1);
    n_tests++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge got %b want 1", s_tready);
    end
  endtask

  task automatic test_back_to_back();
    clear();
    step(1'b1, word(3, 24'h000055), 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, word(1, 24'h000056), 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (m_valid !== 1'b1 || m_sample !== 24'h000055 || s_tready !== (k == 2)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d got vld=%b sig=%h rdy=%b want 1 000055 %b",
                 k, m_valid, m_sample, s_tready, k == 2);
      end
    end
    idle(1'b1);
    n_tests++;
    if (m_valid !== 1'b1 || m_sample !== 24'h000056) begin
      n_fail++;
      $display("FAIL b2b_second got vld=%b sig=%h want 1 000056", m_valid, m_sample);
    end
    idle(1'b1);
    n_tests++;
    if (m_valid !== 1'b0 || sample_count !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_count got vld=%b cnt=%0d want 0 4", m_valid, sample_count);
    end
  endtask

  task automatic test_backpressure();
    clear();
    step(1'b1, word(2, 24'h0000AA), 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      step(1'b1, word(4, 24'h000011), 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (m_valid !== 1'b1 || m_sample !== 24'h0000AA || s_tready !== 1'b0 || m_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall got vld=%b sig=%h rdy=%b last=%b want 1 0000aa 0 0",
                 m_valid, m_sample, s_tready, m_last);
      end
    end
    idle(1'b1);
    n_tests++;
    if (m_sample !== 24'h0000AA || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL release_1 got sig=%h last=%b want 0000aa 0", m_sample, m_last);
    end
    idle(1'b1);
    n_tests++;
    if (m_sample !== 24'h0000AA || m_last !== 1'b1 || m_user !== 2'd3) begin
      n_fail++;
      $display("FAIL release_2 got sig=%h last=%b user=%0d want 0000aa 1 3", m_sample, m_last, m_user);
    end
    idle(1'b1);
  endtask

  task automatic test_overflow();
    clear();
    step(1'b1, word(0, 24'h000000), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, word(0, 24'h000000), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, word(1, 24'h123456), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, word(1, 24'h000077), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (m_sample !== 24'h123456 || m_resync !== 1'b1 || ovf_flag !== 1'b1 || ovf_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf_resync got sig=%h resync=%b flag=%b ovf=%0d want 123456 1 1 2",
               m_sample, m_resync, ovf_flag, ovf_count);
    end
    idle(1'b1);
    n_tests++;
    if (m_sample !== 24'h000077 || m_resync !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_next got sig=%h resync=%b want 000077 0", m_sample, m_resync);
    end
    idle(1'b1);
  endtask

  task automatic test_long();
    int cnt;
    bit done;
    clear();
    step(1'b1, word(255, 24'hFFFFFF), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      idle(1'b1);
      if (m_valid === 1'b1) cnt++;
      else done = 1;
    end
    n_tests++;
    if (!done || cnt != 255 || sample_count !== 32'd255) begin
      n_fail++;
      $display("FAIL rc255 got samples=%0d cnt=%0d idle=%0d want 255 255 1", cnt, sample_count, done);
    end
    repeat (70000) step(1'b1, word(0, 24'($urandom)), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    n_tests++;
    if (ovf_count !== 16'hFFFF || ovf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_saturate got ovf=%h flag=%b want ffff 1", ovf_count, ovf_flag);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    clear();
    step(1'b1, word(10, 24'h0000A5), 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({m_valid, m_last, m_resync, s_tready, m_sample, m_user, sample_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got vld=%b last=%b rdy=%b sig=%h cnt=%0d want all 0",
               m_valid, m_last, s_tready, m_sample, sample_count);
    end
    step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    stray = 0;
    repeat (15) begin
      idle(1'b1);
      if (m_valid !== 1'b0) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL post_reset_samples got %0d want 0", stray);
    end
    step(1'b1, word(0, 24'h0), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, word(5, 24'h0000C3), 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    n_tests++;
    if (m_valid !== 1'b0 || ovf_count !== 16'd0 || ovf_flag !== 1'b0 || sample_count !== 32'd0) begin
      n_fail++;
      $display("FAIL soft_clr got vld=%b ovf=%0d flag=%b cnt=%0d want 0 0 0 0",
               m_valid, ovf_count, ovf_flag, sample_count);
    end
  endtask

  task automatic test_random();
    bit          hv;
    logic [31:0] w;
    logic [1:0]  u;
    logic        l;
    logic        mr;
    logic        clr;
    int          sel;
    int          rc;
    hv = 0; w = '0; u = '0; l = 0;
    clear();
    for (int i = 0; i < 2000; i++) begin
      if (!hv && $urandom_range(0, 2) != 0) begin
        sel = $urandom_range(0, 9);
        rc = (sel < 2) ? 0 : (sel < 6) ? 1 : (sel < 9) ? $urandom_range(2, 4) : $urandom_range(5, 20);
        w = word(rc, 24'($urandom));
        u = 2'($urandom);
        l = 1'($urandom);
        hv = 1;
      end
      mr = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      step(hv, w, u, l, mr, clr, 1'b1);
      if (hv && s_tready === 1'b1) hv = 0;
    end
    repeat (40) idle(1'b1);
    n_tests++;
    if (m_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain got vld=%b pending=%0d want 0 0", m_valid, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    test_long();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/la_trace_decoder.md
LA_TRACE_DECODER -- requirements
Module: la_trace_decoder

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 32, trace word width.
REQ-002 The block SHALL have parameter pSIG_WIDTH, default 24, signal field width in bits [23:0].
REQ-003 The block SHALL have parameter pRC_WIDTH, default 8, repeat-count field width in bits [31:24].
REQ-004 axis_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 axis_rst_n  input  1  asynchronous active-low reset.
REQ-006 s_tdata  input  32  trace word; [31:24] repeat count (rc), [23:0] signals.
REQ-007 s_tvalid / s_tready / s_tlast  input / output / input  1 each  AXI-Stream slave handshake.
REQ-008 s_tuser  input  2  sideband, captured with the word and reported on m_user.
REQ-009 m_sample  output  24  expanded signal sample.
REQ-010 m_valid / m_ready  output / input  1 each  sample handshake, AXI-Stream rules.
REQ-011 m_last  output  1  high on the final sample of a record accepted with s_tlast=1.
REQ-012 m_resync  output  1  high on the first sample after one or more overflow records.
REQ-013 m_user  output  2  s_tuser of the record being expanded.
REQ-014 soft_clr  input  1  synchronous clear of counters, flags and held record.
REQ-015 ovf_flag  output  1  sticky; set by any rc=0 record.
REQ-016 ovf_count  output  16  saturating count of rc=0 records.
REQ-017 sample_count  output  32  wrapping count of samples emitted (m_valid & m_ready).

Function
REQ-018 States SHALL be IDLE (no held record) and EXPAND (held record, remaining count rem > 0).
REQ-019 IDLE: s_tready=1, m_valid=0.
REQ-020 A handshake with rc>0 SHALL latch signals, s_tuser, s_tlast, and rem=rc, then enter EXPAND; the first m_valid follows one cycle later.
REQ-021 A handshake with rc=0 SHALL produce no sample, set ovf_flag, increment ovf_count (saturating at 0xFFFF), set an internal resync-pending bit, and stay in or return to the current state's data path.
REQ-022 EXPAND: m_valid=1, m_sample holds the latched signals; each m_valid&m_ready decrements rem.
REQ-023 s_tready SHALL be 1 in EXPAND only when rem=1 and m_ready=1, which allows back-to-back records with no bubble.
REQ-024 When the last sample is consumed and no new record is accepted in that cycle, the state SHALL return to IDLE.
REQ-025 m_last SHALL be asserted only while rem=1 and the latched tlast=1.
REQ-026 m_resync SHALL be asserted on the first sample of the first rc>0 record after resync-pending was set; resync-pending clears when that sample is consumed.
REQ-027 An rc=0 word accepted while rem=1 is being consumed SHALL count as overflow, and the state SHALL go to IDLE.
REQ-028 m_sample, m_user and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-029 soft_clr SHALL force IDLE and zero rem, ovf_flag, ovf_count, sample_count and resync-pending; it takes priority over any handshake in the same cycle.
REQ-030 rc=255 SHALL yield exactly 255 samples; rem SHALL be pRC_WIDTH bits wide with no wrap.

Reset
REQ-031 On axis_rst_n=0 the block SHALL be in IDLE with s_tready=0 during reset, and m_valid=0, m_last=0, m_resync=0, m_sample=0, m_user=0, ovf_flag=0, ovf_count=0 and sample_count=0.
REQ-032 s_tready SHALL rise no earlier than the first clock edge after reset deasserts.
REQ-033 Reset asserted mid-EXPAND SHALL discard the held record, and no sample of that record SHALL appear after reset.

Structure
REQ-034 The shared package la_pkg SHALL hold pSIG_WIDTH, pRC_WIDTH, the field bit positions, and the state enumeration; the LA encoder uses the same package.
REQ-035 One sub-module, la_sat_counter (parameterised width, saturate or wrap select), SHALL implement ovf_count and sample_count.

Verification
REQ-036 Send rc=3 sig=0x000055 then rc=1 sig=0x000056 with m_ready=1 -> samples 55,55,55,56 on four consecutive cycles; s_tready shows no bubble; sample_count=4.
REQ-037 Send rc=2 sig=0x0000AA with tlast=1, holding m_ready=0 for 5 cycles -> m_sample=AA stays stable, s_tready=0; after release, two samples with m_last only on the second.
REQ-038 Send rc=0, rc=0, then rc=1 sig=0x123456 -> ovf_flag=1, ovf_count=2, one sample 123456 with m_resync=1; the next record has m_resync=0.
REQ-039 Send rc=255 sig=0xFFFFFF -> exactly 255 samples, then IDLE; 70000 rc=0 words -> ovf_count=0xFFFF.
REQ-040 Assert axis_rst_n=0 after 2 of 10 samples of an rc=10 record -> all outputs at reset values and no further samples; assert soft_clr while a handshake occurs -> record dropped, counters zero.
